bcd_serial_add_ctrl: RTL and testbench
======================================

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter NDIG, default 4, gives the number of BCD digits per operand.
REQ-002 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to add A and B; sampled only in IDLE.
REQ-005 A  input  4*NDIG  operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 B  input  4*NDIG  operand B, packed BCD, same packing as A.
REQ-007 Cin  input  1  carry into digit 0.
REQ-008 Sum  output  4*NDIG  registered packed BCD result of the last completed operation.
REQ-009 Cout  output  1  registered carry out of digit NDIG-1 for the last completed operation.
REQ-010 Busy  output  1  high while the block is in ADD.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 Err  output  1  invalid-digit flag for the last completed operation.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-014 In IDLE with Start=1, the edge SHALL capture A, B and Cin into internal registers, clear the digit counter and the error accumulator, and enter ADD.
REQ-015 In ADD, each edge SHALL add digit[cnt] of the captured A and B plus the carry register through one digit adder.
REQ-016 Each ADD edge SHALL write the result digit into working-register slot cnt, update the carry register and increment cnt.
REQ-017 After the edge that processes cnt=NDIG-1, the FSM SHALL enter DONE; ADD therefore lasts exactly NDIG cycles.
REQ-018 The edge entering DONE SHALL load Sum from the working register, load Cout from the final carry and load Err from the accumulator.
REQ-019 Done SHALL be 1 for exactly the one cycle spent in DONE; the next edge returns the FSM to IDLE unconditionally.
REQ-020 Counting the Start-capturing edge as edge 1, Done SHALL go high after edge NDIG+1.
REQ-021 Busy SHALL be 1 only in ADD.
REQ-022 Busy and Done SHALL never be high together.
REQ-023 Start SHALL be ignored in ADD and DONE; captured operands are unaffected by input changes after capture.
REQ-024 Digit adder: s = a + b + c, with range 0..31. If s > 9, the result digit is (s+6) mod 16 and carry-out is 1. Otherwise the result digit is s and carry-out is 0.
REQ-025 An operand digit greater than 9 in captured A or B SHALL set the error accumulator; arithmetic proceeds per REQ-024 regardless.
REQ-026 Sum, Cout and Err SHALL hold their values from the edge entering DONE until the next edge entering DONE.
REQ-027 Sum, Cout and Err SHALL not change during ADD.
REQ-028 Back-to-back operation: Start asserted in the IDLE cycle immediately after DONE SHALL be accepted, giving a minimum issue interval of NDIG+2 cycles.

Reset
REQ-029 Reset=1 at an edge SHALL force IDLE and clear cnt, the carry register, the working register and the captured operands.
REQ-030 Reset=1 at an edge SHALL clear Sum, Cout, Busy, Done and Err to 0.
REQ-031 Reset SHALL take priority over Start and over all state transitions.
REQ-032 Reset asserted mid-ADD SHALL abort the operation; no Done pulse follows for it.

Structure
REQ-033 A shared package bcd_pkg SHALL hold the NDIG default, the FSM state enum (IDLE/ADD/DONE), BCD_MAX=9 and BCD_CORR=6.
REQ-034 The digit adder SHALL be a separate combinational sub-module, bcd_digit_add, with ports a[3:0], b[3:0], cin, s[3:0] and cout; exactly one instance is used.

Verification
REQ-035 Reset, then A=0x1234, B=0x5678, Cin=0, Start pulse -> Busy high 4 cycles; Done after edge 5; Sum=0x6912, Cout=0, Err=0.
REQ-036 A=0x9999, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1.
REQ-037 A=0x9999, B=0x9999, Cin=1 -> Sum=0x9999, Cout=1.
REQ-038 Start held high through ADD with operands changed to 0x1111/0x1111 after capture of 0x0005/0x0005 -> one Done only; Sum=0x0010.
REQ-039 Next Start accepted the cycle after Done -> second Done exactly NDIG+2 cycles after the first.
REQ-040 A=0x00A0, B=0x0000 -> Err=1 with Done; a following valid add (0x0001+0x0001) -> Err=0, Sum=0x0002.
REQ-041 Reset asserted during the 2nd ADD cycle -> Busy=0 next cycle; no Done; Sum=0, Cout=0, Err=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial BCD adder: default operand width in
// digits, BCD digit limits and the controller state encoding.
// ---------------------------------------------------------------------------
package bcd_pkg;

   localparam int         NDIG_DEFAULT = 4;
   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] BCD_CORR     = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } bcd_state_e;

endpackage : bcd_pkg

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Purely combinational single-digit BCD adder.
// Ports:
//   a, b  : input digits (values 10..15 are added arithmetically anyway)
//   cin   : carry in
//   s     : result digit
//   cout  : decimal carry out
// ---------------------------------------------------------------------------
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] raw_sum;

   always_comb begin
      raw_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      s       = raw_sum[3:0];
      cout    = 1'b0;
      // Binary sums above 9 are pushed past 15 by +6, so the low nibble
      // wraps to the decimal digit and the carry moves up.
      if (raw_sum > {1'b0, BCD_MAX}) begin
         s    = raw_sum[3:0] + BCD_CORR;
         cout = 1'b1;
      end
   end

endmodule : bcd_digit_add

// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
// Serial packed-BCD adder: one digit per clock through a single digit adder.
// Handshake: Start is a request sampled only while idle; the operands and
// Cin are captured on that edge. Busy is high for exactly NDIG cycles while
// digits are processed, then Done pulses for one cycle with Sum/Cout/Err
// already updated. Results hold until the next Done.
// Ports:
//   CLOCK_50  : clock, rising edge
//   Reset     : synchronous active-high reset
//   Start     : add request
//   A, B      : packed BCD operands, digit 0 in bits [3:0]
//   Cin       : carry into digit 0
//   Sum, Cout : registered result of the last completed addition
//   Busy      : high while digits are being added
//   Done      : one-cycle completion pulse
//   Err       : an operand of the last completed addition had a digit > 9
//   state_dbg : current controller state (bcd_state_e encoding)
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int NDIG = NDIG_DEFAULT
) (
   input  logic              CLOCK_50,
   input  logic              Reset,
   input  logic              Start,
   input  logic [4*NDIG-1:0] A,
   input  logic [4*NDIG-1:0] B,
   input  logic              Cin,
   output logic [4*NDIG-1:0] Sum,
   output logic              Cout,
   output logic              Busy,
   output logic              Done,
   output logic              Err,
   output logic [1:0]        state_dbg
);

   localparam int W  = 4 * NDIG;
   localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

   bcd_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  work_q, work_d;
   logic          err_acc_q, err_acc_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          err_q, err_d;

   logic [CW+1:0] bit_base;
   logic [3:0]    a_dig, b_dig, dig_s;
   logic          dig_cout, dig_err;

   // Bit offset of the digit currently being processed.
   assign bit_base = {cnt_q, 2'b00};
   assign a_dig    = a_q[bit_base +: 4];
   assign b_dig    = b_q[bit_base +: 4];
   assign dig_err  = (a_dig > BCD_MAX) || (b_dig > BCD_MAX);

   bcd_digit_add u_digit_add (
      .a    (a_dig),
      .b    (b_dig),
      .cin  (carry_q),
      .s    (dig_s),
      .cout (dig_cout)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      work_d    = work_q;
      err_acc_d = err_acc_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            if (Start) begin
               a_d       = A;
               b_d       = B;
               carry_d   = Cin;
               cnt_d     = '0;
               err_acc_d = 1'b0;
               state_d   = ADD;
            end
         end

         ADD: begin
            work_d[bit_base +: 4] = dig_s;
            carry_d   = dig_cout;
            err_acc_d = err_acc_q | dig_err;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               // Results are taken from the next-state values so the digit
               // processed on this final edge is included.
               sum_d   = work_d;
               cout_d  = dig_cout;
               err_d   = err_acc_d;
               cnt_d   = '0;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         work_q    <= '0;
         err_acc_q <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         a_q       <= a_d;
         b_q       <= b_d;
         work_q    <= work_d;
         err_acc_q <= err_acc_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         err_q     <= err_d;
      end
   end

   assign Sum       = sum_q;
   assign Cout      = cout_q;
   assign Err       = err_q;
   assign Busy      = (state_q == ADD);
   assign Done      = (state_q == DONE);
   assign state_dbg = state_q;

endmodule : bcd_serial_add_ctrl

// File: tb/tb_bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
// Self-checking bench: the driver issues additions and pushes the expected
// {Err, Cout, Sum} and Done cycle into queues; a monitor on the falling edge
// pops and compares whenever Done is seen.
// ---------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;

   logic         CLOCK_50;
   logic         Reset;
   logic         Start;
   logic [W-1:0] A, B;
   logic         Cin;
   logic [W-1:0] Sum;
   logic         Cout, Busy, Done, Err;
   logic [1:0]   state_dbg;

   bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
      .CLOCK_50  (CLOCK_50),
      .Reset     (Reset),
      .Start     (Start),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .Sum       (Sum),
      .Cout      (Cout),
      .Busy      (Busy),
      .Done      (Done),
      .Err       (Err),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset block ----------------
   int cyc = 0;

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [W+1:0] exp_q[$];
   int           exp_cyc_q[$];
   int           done_cyc_q[$];
   int           n_cmp  = 0;
   int           n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: decimal digit-by-digit addition with plain arithmetic.
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin);
      int           c, s, ad, bd;
      logic [W-1:0] sum;
      logic         err;
      c   = int'(cin);
      sum = '0;
      err = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         ad = int'((a >> (4 * i)) & 16'hF);
         bd = int'((b >> (4 * i)) & 16'hF);
         if (ad > 9 || bd > 9) err = 1'b1;
         s = ad + bd + c;
         if (s > 9) begin
            s = (s + 6) % 16;
            c = 1;
         end else begin
            c = 0;
         end
         sum = sum | (W'(s) << (4 * i));
      end
      return {err, (c != 0), sum};
   endfunction

   // ---------------- monitor ----------------
   initial begin
      logic [W+1:0] rec;
      int           ecyc;
      int           busy_run;
      bit           have_prev;
      logic [W+1:0] prev_out;
      busy_run  = 0;
      have_prev = 0;
      prev_out  = '0;
      forever begin
         @(negedge CLOCK_50);
         if (Reset) begin
            busy_run  = 0;
            have_prev = 0;
         end else begin
            if (Busy || Done) check("busy_done_exclusive", {63'd0, Busy && Done}, 64'd0);
            if (Busy && have_prev) check("result_stable_in_add", {Err, Cout, Sum}, prev_out);
            if (Busy) begin
               busy_run++;
            end else if (Done) begin
               check("busy_length", busy_run, NDIG);
               busy_run = 0;
               done_cyc_q.push_back(cyc);
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 64'd1, 64'd0);
               end else begin
                  rec  = exp_q.pop_front();
                  ecyc = exp_cyc_q.pop_front();
                  check("sum",        Sum,  rec[W-1:0]);
                  check("cout",       Cout, rec[W]);
                  check("err",        Err,  rec[W+1]);
                  check("done_cycle", cyc,  ecyc);
               end
            end else begin
               busy_run = 0;
            end
            prev_out  = {Err, Cout, Sum};
            have_prev = 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called #1 after a rising edge with the DUT idle; returns #1 after the
   // edge that brings it back to idle, so calls can be chained back-to-back.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit hold);
      A     = a;
      B     = b;
      Cin   = cin;
      Start = 1'b1;
      @(posedge CLOCK_50); #1;
      exp_q.push_back(ref_add(a, b, cin));
      exp_cyc_q.push_back(cyc + NDIG);
      if (hold) begin
         A = 16'h1111;
         B = 16'h1111;
      end else begin
         A     = W'($urandom);
         B     = W'($urandom);
         Cin   = 1'($urandom);
         Start = 1'b0;
      end
      for (int k = 1; k <= NDIG + 1; k++) begin
         @(posedge CLOCK_50); #1;
         if (!hold && k < NDIG) Start = 1'($urandom);
         if (k >= NDIG) Start = 1'b0;
      end
   endtask

   function automatic logic [W-1:0] rand_operand();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < NDIG; i++) begin
         if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(0, 15));
         else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int d0, d1;
      Reset = 1'b1;
      Start = 1'b0;
      A     = '0;
      B     = '0;
      Cin   = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      check("reset_sum",   Sum,       '0);
      check("reset_cout",  Cout,      1'b0);
      check("reset_busy",  Busy,      1'b0);
      check("reset_done",  Done,      1'b0);
      check("reset_err",   Err,       1'b0);
      check("reset_state", state_dbg, bcd_pkg::IDLE);
      Reset = 1'b0;

      // Directed additions, issued back-to-back.
      issue(16'h1234, 16'h5678, 1'b0, 0);
      issue(16'h9999, 16'h0001, 1'b0, 0);
      if (done_cyc_q.size() >= 2) begin
         d0 = done_cyc_q[done_cyc_q.size() - 2];
         d1 = done_cyc_q[done_cyc_q.size() - 1];
         check("back_to_back_interval", d1 - d0, NDIG + 2);
      end else begin
         check("back_to_back_dones_seen", done_cyc_q.size(), 2);
      end
      issue(16'h9999, 16'h9999, 1'b1, 0);
      issue(16'h0005, 16'h0005, 1'b0, 1);
      issue(16'h00A0, 16'h0000, 1'b0, 0);
      issue(16'h0001, 16'h0001, 1'b0, 0);

      // Abort during the second ADD cycle: no Done, results cleared.
      A     = 16'h3456;
      B     = 16'h1111;
      Cin   = 1'b0;
      Start = 1'b1;
      @(posedge CLOCK_50); #1;
      Start = 1'b0;
      @(posedge CLOCK_50); #1;
      Reset = 1'b1;
      @(posedge CLOCK_50); #1;
      Reset = 1'b0;
      check("abort_busy",  Busy,      1'b0);
      check("abort_done",  Done,      1'b0);
      check("abort_sum",   Sum,       '0);
      check("abort_cout",  Cout,      1'b0);
      check("abort_err",   Err,       1'b0);
      check("abort_state", state_dbg, bcd_pkg::IDLE);
      repeat (NDIG + 3) begin
         @(posedge CLOCK_50); #1;
      end

      // Randomized additions with occasional idle gaps.
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge CLOCK_50); #1;
         end
         issue(rand_operand(), rand_operand(), 1'($urandom), 1'($urandom_range(0, 5) == 0));
      end

      repeat (4) begin
         @(posedge CLOCK_50); #1;
      end
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_bcd_serial_add_ctrl
